// File: rtl/stack_unit_if.sv
// stack_unit_if: push/pop/peek bus and status signals of a stack_unit instance.
//   master drives push, pop, din, clr_err and peek_idx; slave (the stack) drives
//   dout, peek_data, count, full, empty, overflow and underflow.
interface stack_unit_if #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16,
   localparam int CW = $clog2(DEPTH + 1)
);
   logic             push;
   logic             pop;
   logic             clr_err;
   logic [WIDTH-1:0] din;
   logic [CW-1:0]    peek_idx;
   logic [WIDTH-1:0] dout;
   logic [WIDTH-1:0] peek_data;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             underflow;
   modport master (
      output push, pop, clr_err, din, peek_idx,
      input  dout, peek_data, count, full, empty, overflow, underflow
   );
   modport slave (
      input  push, pop, clr_err, din, peek_idx,
      output dout, peek_data, count, full, empty, overflow, underflow
   );
endinterface

// File: rtl/stack_unit.sv
// stack_unit: parametrised LIFO with occupancy, full/empty, sticky error flags,
//   single-cycle replace (push+pop) and an indexed peek port.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears count and flags, not storage)
//   bus   : stack_unit_if.slave carrying push/pop/din/clr_err/peek_idx in and
//           dout/peek_data/count/full/empty/overflow/underflow out
module stack_unit #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int AW = $clog2(DEPTH)
) (
   input logic         clk,
   input logic         rst_n,
   stack_unit_if.slave bus
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             full, empty, do_push, do_pop, do_rep, we, peek_ok;
   logic [AW-1:0]    top, wa, pidx;
   always_comb begin
      full    = count_q == CW'(DEPTH);
      empty   = count_q == '0;
      do_push = bus.push & ~bus.pop & ~full;
      do_pop  = bus.pop & ~bus.push & ~empty;
      do_rep  = bus.push & bus.pop & ~empty;
      top     = AW'(count_q - CW'(1));
      pidx    = AW'(count_q - CW'(1) - bus.peek_idx);
      peek_ok = bus.peek_idx < count_q;
      we      = do_push | do_rep;
      // a replace overwrites the current top; a plain push lands one above it
      wa      = do_push ? AW'(count_q) : top;
      count_d = do_push ? count_q + CW'(1) : do_pop ? count_q - CW'(1) : count_q;
      // setting beats clearing when both happen in the same cycle
      ovf_d   = (ovf_q & ~bus.clr_err) | (bus.push & ~bus.pop & full);
      unf_d   = (unf_q & ~bus.clr_err) | (bus.pop & empty);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end
   // storage is never cleared; a write coinciding with reset is dropped
   always_ff @(posedge clk) begin
      if (we && rst_n) mem_q[wa] <= bus.din;
   end
   assign bus.dout      = empty ? '0 : mem_q[top];
   assign bus.peek_data = peek_ok ? mem_q[pidx] : '0;
   assign bus.count     = count_q;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Parametrised LIFO for the processor: one instance holds return addresses for jal/ret, another holds register data for push/pop.
- Successor to the fixed two-parameter stack in the single-cycle datapath.
- Adds occupancy count, full/empty status, sticky overflow/underflow error flags with clear, single-cycle replace (push+pop), and an indexed peek port for debug and the future multi-cycle core.

Parameters:
WIDTH, 10, data bits per entry (10 = return-address stack, 8 = data stack)
DEPTH, 16, number of entries; any value >= 2
CW, $clog2(DEPTH+1), width of count and peek index (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
push  input  1  write din onto stack this cycle
pop  input  1  remove top entry this cycle
din  input  WIDTH  data to push
clr_err  input  1  clear sticky overflow/underflow flags
peek_idx  input  CW  entry index below top for peek (0 = top)
dout  output  WIDTH  current top of stack (combinational from storage)
peek_data  output  WIDTH  entry at top-peek_idx (combinational)
count  output  CW  number of valid entries
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, overflow=0, underflow=0. Storage contents are not cleared.
  - dout=0 and peek_data=0 while empty.
  - Deassertion is sampled at the next rising clk.
- Storage: DEPTH x WIDTH register array; stack pointer = count; top entry = mem[count-1].
- All updates occur on the rising clk edge. The new top appears on dout in the same cycle the edge completes, i.e. zero-latency visibility after the edge.
- push=1, pop=0, not full: mem[count] <= din; count+1.
- push=1, pop=0, full: no write, count unchanged, overflow <= 1.
- pop=1, push=0, not empty: count-1; the popped value was visible on dout during the pop cycle, matching the current ret/pop datapath timing.
- pop=1, push=0, empty: count stays 0, underflow <= 1.
- push=1, pop=1, not empty (replace):
  - mem[count-1] <= din; count unchanged.
  - Legal when full; does not set overflow.
- push=1, pop=1, empty: no write, count stays 0, underflow <= 1.
- clr_err=1: overflow, underflow <= 0. If an error event occurs in the same cycle, set wins and the flag is 1 afterwards.
- Flags hold until clr_err or reset; they never affect push/pop acceptance.
- full/empty: combinational decodes of count.
- dout: mem[count-1] when count>0, else 0.
- peek_data: mem[count-1-peek_idx] when peek_idx < count, else 0. No wrap-around.
- Writes to entries above count leave other entries untouched. Popped entries are stale, not cleared.
- Reset asserted mid-operation: count and flags clear immediately; any push in that cycle is discarded.

Test Plan:
- Reset then idle -> count=0, empty=1, full=0, dout=0, overflow=0, underflow=0.
- WIDTH=10, DEPTH=4: push 0x101, 0x202, 0x303 -> count=3, dout=0x303, peek_idx=2 gives 0x101, peek_idx=3 gives 0. Pop twice -> dout=0x101, count=1.
- Fill DEPTH=4 with 1,2,3,4 -> full=1; push 5 -> count=4, dout=4, overflow=1. push+pop din=9 -> dout=9, count=4, no new error. clr_err -> overflow=0.
- Empty stack: pop -> underflow=1, count=0. push+pop din=7 -> count=0, underflow=1. clr_err together with pop on empty -> underflow remains 1.
- Push 0xAA, 0xBB (WIDTH=8); assert reset low mid-cycle together with push 0xCC -> count=0 immediately, dout=0. After release, push 0x11 -> dout=0x11, count=1.
- Random push/pop/peek over 10k cycles, DEPTH=16, against a reference queue model -> dout, peek_data, count and flags match every cycle.
